// File: rtl/sprite_load_scheduler.sv
// On each hsync rising edge, walks the enabled sprites in index order. Each gets a one-cycle load pulse and a
// SLOT_CYCLES-long slot owning the shared bitmap ROM; rom_sel is registered, rom_addr is a combinational mux.
module sprite_load_scheduler #(
    parameter int NUM_SPRITES = 4,
    parameter int SLOT_CYCLES = 4,
    parameter int ADDR_W      = 4,
    parameter int SEL_W       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hsync,
    input  logic                          vsync,
    input  logic [NUM_SPRITES-1:0]        sprite_en,
    input  logic [NUM_SPRITES*ADDR_W-1:0] rom_addr_in,
    output logic [NUM_SPRITES-1:0]        load,
    output logic [SEL_W-1:0]              rom_sel,
    output logic [ADDR_W-1:0]             rom_addr,
    output logic                          busy,
    output logic                          overrun
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SLOT, DONE} state_t;

    state_t                 state, state_d;
    logic                   hsync_q, vsync_q;
    logic                   hs_start, vs_start;
    logic [NUM_SPRITES-1:0] mask, mask_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [SEL_W-1:0]       sel_d;
    logic [NUM_SPRITES-1:0] load_d;
    logic                   busy_d, overrun_d;

    logic                   first_vld, next_vld;
    logic [SEL_W-1:0]       first_idx, next_idx;
    logic [NUM_SPRITES-1:0] first_oh, next_oh;

    assign hs_start = hsync & ~hsync_q;
    assign vs_start = vsync & ~vsync_q;

    // Lowest enabled sprite (for a new sequence) and lowest latched sprite above the current one.
    always_comb begin
        first_vld = 1'b0;
        first_idx = '0;
        first_oh  = '0;
        next_vld  = 1'b0;
        next_idx  = '0;
        next_oh   = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (sprite_en[i]) begin
                first_vld   = 1'b1;
                first_idx   = SEL_W'(i);
                first_oh    = '0;
                first_oh[i] = 1'b1;
            end
            if (mask[i] && (i > int'(rom_sel))) begin
                next_vld   = 1'b1;
                next_idx   = SEL_W'(i);
                next_oh    = '0;
                next_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state;
        mask_d    = mask;
        cnt_d     = cnt;
        sel_d     = rom_sel;
        load_d    = '0;
        busy_d    = busy;
        overrun_d = overrun;
        if (vs_start) overrun_d = 1'b0;
        if (hs_start && (state != IDLE)) overrun_d = 1'b1;
        case (state)
            IDLE: begin
                if (hs_start) begin
                    mask_d = sprite_en;
                    if (first_vld) begin
                        sel_d   = first_idx;
                        load_d  = first_oh;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = SLOT;
                    end
                end
            end
            SLOT: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    if (next_vld) begin
                        sel_d  = next_idx;
                        load_d = next_oh;
                        cnt_d  = '0;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            mask    <= '0;
            cnt     <= '0;
            rom_sel <= '0;
            load    <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_d;
            hsync_q <= hsync;
            vsync_q <= vsync;
            mask    <= mask_d;
            cnt     <= cnt_d;
            rom_sel <= sel_d;
            load    <= load_d;
            busy    <= busy_d;
            overrun <= overrun_d;
        end
    end

    always_comb begin
        rom_addr = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (rom_sel == SEL_W'(i)) rom_addr = rom_addr_in[i*ADDR_W +: ADDR_W];
        end
    end

endmodule
